// File: rtl/audio_pkg.sv
// Shared types and constants for the PWM audio path: sample width, silence
// level and the feeder handshake states.
package audio_pkg;

    localparam int AUDIO_WORD_LENGTH = 16;

    // PWM midscale, heard as silence
    localparam logic [AUDIO_WORD_LENGTH-1:0] AUDIO_SILENCE_WORD = 16'h8000;

    typedef logic [AUDIO_WORD_LENGTH-1:0] audio_sample_t;

    typedef enum logic [1:0] {
        FEEDER_IDLE    = 2'd0,
        FEEDER_SEND    = 2'd1,
        FEEDER_RELEASE = 2'd2
    } feeder_state_t;

endpackage

// File: rtl/audio_sync_fifo.sv
// Single-clock FIFO with occupancy count; combinational read of the head entry,
// no write-to-read bypass, synchronous active-low reset of pointers and level.
module audio_sync_fifo
    import audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_WORD_LENGTH,
    parameter int DEPTH = 16
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic              wr_ok;
    logic              rd_ok;

    assign full_o    = (level == (ADDR_W+1)'(DEPTH));
    assign empty_o   = (level == '0);
    assign level_o   = level;
    assign rd_data_o = mem[rd_ptr];

    // Full/empty are judged on the registered level, so a write into a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign wr_ok = wr_en_i && !full_o;
    assign rd_ok = rd_en_i && !empty_o;

    always_ff @(posedge clock_i) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// Feeds buffered samples to the PWM serializer one word per enable/done handshake,
// substituting a fill word on underrun. Define AUDIO_SAMPLE_FEEDER_HOLD_LAST_EN to repeat the last sample instead of silence.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int                     WORD_LENGTH  = AUDIO_WORD_LENGTH,
    parameter int                     DEPTH        = 16,
    parameter logic [WORD_LENGTH-1:0] SILENCE_WORD = AUDIO_SILENCE_WORD
) (
    input  logic                       clock_i,
    input  logic                       reset_n_i,
    input  logic                       wr_en_i,
    input  logic [WORD_LENGTH-1:0]     wr_data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    input  logic                       play_i,
    output logic                       ser_enable_o,
    output logic [WORD_LENGTH-1:0]     ser_data_o,
    input  logic                       ser_done_i,
    output logic                       overflow_o,
    output logic [15:0]                underrun_cnt_o
);

    feeder_state_t          state;
    logic [WORD_LENGTH-1:0] head_data;
    logic [WORD_LENGTH-1:0] fill_word;
    logic                   pop;
    logic                   start;

    assign start = (state == FEEDER_IDLE) && play_i;
    assign pop   = start && !empty_o;

    audio_sync_fifo #(
        .WIDTH (WORD_LENGTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .wr_en_i   (wr_en_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (pop),
        .rd_data_o (head_data),
        .full_o    (full_o),
        .empty_o   (empty_o),
        .level_o   (level_o)
    );

`ifdef AUDIO_SAMPLE_FEEDER_HOLD_LAST_EN
    logic [WORD_LENGTH-1:0] last_sample;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            last_sample <= SILENCE_WORD;
        end else if (pop) begin
            last_sample <= head_data;
        end
    end

    assign fill_word = last_sample;
`else
    assign fill_word = SILENCE_WORD;
`endif

    // Enable is decoded from the state register so it drops on the reset edge.
    assign ser_enable_o = (state == FEEDER_SEND);

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state          <= FEEDER_IDLE;
            ser_data_o     <= '0;
            underrun_cnt_o <= '0;
        end else begin
            case (state)
                FEEDER_IDLE: begin
                    if (play_i) begin
                        state <= FEEDER_SEND;
                        if (!empty_o) begin
                            ser_data_o <= head_data;
                        end else begin
                            ser_data_o <= fill_word;
                            if (underrun_cnt_o != 16'hFFFF) begin
                                underrun_cnt_o <= underrun_cnt_o + 16'd1;
                            end
                        end
                    end
                end
                FEEDER_SEND: begin
                    if (ser_done_i) begin
                        state <= FEEDER_RELEASE;
                    end
                end
                FEEDER_RELEASE: begin
                    if (!ser_done_i) begin
                        state <= FEEDER_IDLE;
                    end
                end
                default: state <= FEEDER_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            overflow_o <= 1'b0;
        end else if (wr_en_i && full_o) begin
            overflow_o <= 1'b1;
        end
    end

endmodule
